ula_seq_nbits: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit cascaded 74181 ALU.
- Processes a WIDTH-bit operation one 4-bit slice per clock through a single ula_74181 instance. Carry ripples through a register between slices.
- Trades latency for area. Adds a start/busy/done handshake and registered results so it can sit on a clocked datapath.

---
 rtl/ula_seq_nbits.sv | 218 +++++++++++++++++++++
 tb/tb_ula_seq_nbits.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq_nbits.sv
// ---------------------------------------------------------------------------
// ula_seq_nbits
//   Multi-cycle WIDTH-bit 74181-style ALU. One 4-bit slice is evaluated per
//   clock through a single ula_74181 instance; the slice carry is held in a
//   register between clocks. Results are registered and presented with a
//   one-cycle done pulse.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, sampled in IDLE or DONE
//   a, b    in   WIDTH-bit operands, captured on the accepting edge
//   s       in   74181 function select, captured on the accepting edge
//   m       in   mode: 1 = logic, 0 = arithmetic
//   c_in    in   carry into slice 0 (1 = no carry, 74181 polarity)
//   busy    out  high while slices are being computed
//   done    out  one-cycle result-valid pulse
//   f       out  registered result
//   a_eq_b  out  registered AND of every slice A=B output
//   c_out   out  registered carry out of the top slice (0 = carry generated)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// ula_74181
//   Combinational 4-bit 74181 slice, active-high data.
//
// Ports
//   a, b    in   4-bit operands
//   s       in   function select
//   m       in   mode: 1 = logic, 0 = arithmetic
//   c_n     in   carry in (1 = no carry)
//   f       out  4-bit result
//   a_eq_b  out  AND of all result bits
//   c_n4    out  carry out (0 = carry generated)
// ---------------------------------------------------------------------------
module ula_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_n,
  output logic [3:0] f,
  output logic       a_eq_b,
  output logic       c_n4
);

  logic [3:0] op_x;
  logic [3:0] op_y;
  logic [4:0] sum;

  // Every 74181 function is op_x plus op_y (plus carry) in arithmetic mode,
  // and the carry-free half-sum, inverted, in logic mode.
  always_comb begin
    op_x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    op_y   = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
    sum    = {1'b0, op_x} + {1'b0, op_y} + {4'b0000, ~c_n};
    f      = m ? ~(op_x ^ op_y) : sum[3:0];
    c_n4   = ~sum[4];
    a_eq_b = &f;
  end

endmodule

// state | meaning
// IDLE  | waiting for start
// BUSY  | one slice per clock, slice index 0 .. NSLICE-1
// DONE  | result valid for one cycle; start here chains a new operation
module ula_seq_nbits #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             a_eq_b,
  output logic             c_out
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("ula_seq_nbits: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_nx;
  logic             accept;
  logic             slice_en;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       s_reg;
  logic             m_reg;
  logic             carry_q;
  logic             eq_acc;
  logic [IW-1:0]    slice_idx;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] partial_nx;

  logic [IW+1:0]    bit_ofs;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_f;
  logic             slice_eq;
  logic             slice_cout;

  // Slice k occupies bits [4k+3:4k]; shifting by 4k avoids a wide mux tree
  // on a variable part-select.
  assign bit_ofs = {slice_idx, 2'b00};
  assign slice_a = 4'(a_reg >> bit_ofs);
  assign slice_b = 4'(b_reg >> bit_ofs);

  ula_74181 u_slice (
    .a      (slice_a),
    .b      (slice_b),
    .s      (s_reg),
    .m      (m_reg),
    .c_n    (carry_q),
    .f      (slice_f),
    .a_eq_b (slice_eq),
    .c_n4   (slice_cout)
  );

  // Partial result with the current slice merged in; on the last slice this
  // is the complete result loaded into f.
  assign partial_nx = (partial & ~(WIDTH'(4'hF) << bit_ofs))
                    | (WIDTH'(slice_f) << bit_ofs);

  always_comb begin
    state_nx = state_q;
    accept   = 1'b0;
    slice_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        slice_en = 1'b1;
        if (slice_idx == LAST_IDX) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      m_reg     <= 1'b0;
      carry_q   <= 1'b0;
      eq_acc    <= 1'b0;
      slice_idx <= '0;
      partial   <= '0;
      f         <= '0;
      a_eq_b    <= 1'b0;
      c_out     <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        s_reg     <= s;
        m_reg     <= m;
        carry_q   <= c_in;
        eq_acc    <= 1'b1;
        slice_idx <= '0;
      end
      if (slice_en) begin
        partial <= partial_nx;
        carry_q <= slice_cout;
        eq_acc  <= eq_acc & slice_eq;
        if (slice_idx == LAST_IDX) begin
          f      <= partial_nx;
          c_out  <= slice_cout;
          a_eq_b <= eq_acc & slice_eq;
        end else begin
          slice_idx <= slice_idx + 1'b1;
        end
      end
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_ula_seq_nbits.sv
module tb_ula_seq_nbits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  s;
  logic        m;
  logic        c_in;
  logic        st8, st12, st16, st32;

  logic        busy8, done8, eq8, co8;
  logic [7:0]  f8;
  logic        busy12, done12, eq12, co12;
  logic [11:0] f12;
  logic        busy16, done16, eq16, co16;
  logic [15:0] f16;
  logic        busy32, done32, eq32, co32;
  logic [31:0] f32;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ula_seq_nbits #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a[7:0]), .b(b[7:0]), .s(s),
    .m(m), .c_in(c_in), .busy(busy8), .done(done8), .f(f8), .a_eq_b(eq8),
    .c_out(co8));
  ula_seq_nbits #(.WIDTH(12)) u_w12 (
    .clk(clk), .rst_n(rst_n), .start(st12), .a(a[11:0]), .b(b[11:0]), .s(s),
    .m(m), .c_in(c_in), .busy(busy12), .done(done12), .f(f12), .a_eq_b(eq12),
    .c_out(co12));
  ula_seq_nbits #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .a(a[15:0]), .b(b[15:0]), .s(s),
    .m(m), .c_in(c_in), .busy(busy16), .done(done16), .f(f16), .a_eq_b(eq16),
    .c_out(co16));
  ula_seq_nbits #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .a(a), .b(b), .s(s),
    .m(m), .c_in(c_in), .busy(busy32), .done(done32), .f(f32), .a_eq_b(eq32),
    .c_out(co32));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      8:       st8  = v;
      12:      st12 = v;
      16:      st16 = v;
      default: st32 = v;
    endcase
  endtask

  task automatic get_out(input int w, output logic [31:0] fo, output logic bo,
                         output logic dn, output logic eo, output logic co);
    case (w)
      8:       begin fo = {24'h0, f8};  bo = busy8;  dn = done8;  eo = eq8;  co = co8;  end
      12:      begin fo = {20'h0, f12}; bo = busy12; dn = done12; eo = eq12; co = co12; end
      16:      begin fo = {16'h0, f16}; bo = busy16; dn = done16; eo = eq16; co = co16; end
      default: begin fo = f32;          bo = busy32; dn = done32; eo = eq32; co = co32; end
    endcase
  endtask

  // Reference: the 74181 function table applied to the whole word at once.
  // Arithmetic functions are written as X plus Y plus carry, with "minus 1"
  // expressed as adding all ones so the top carry falls out of the sum.
  function automatic void model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                input logic [3:0] si, input logic mi, input logic ci,
                                output logic [31:0] fo, output logic co, output logic eq);
    logic [32:0] msk, av, bv, nb, x, y, sm, lg;
    msk = (33'd1 << w) - 33'd1;
    av  = {1'b0, ai} & msk;
    bv  = {1'b0, bi} & msk;
    nb  = ~bv & msk;
    case (si)
      4'h0: begin x = av;       y = '0;       end
      4'h1: begin x = av | bv;  y = '0;       end
      4'h2: begin x = av | nb;  y = '0;       end
      4'h3: begin x = msk;      y = '0;       end
      4'h4: begin x = av;       y = av & nb;  end
      4'h5: begin x = av | bv;  y = av & nb;  end
      4'h6: begin x = av;       y = nb;       end
      4'h7: begin x = av & nb;  y = msk;      end
      4'h8: begin x = av;       y = av & bv;  end
      4'h9: begin x = av;       y = bv;       end
      4'hA: begin x = av | nb;  y = av & bv;  end
      4'hB: begin x = av & bv;  y = msk;      end
      4'hC: begin x = av;       y = av;       end
      4'hD: begin x = av | bv;  y = av;       end
      4'hE: begin x = av | nb;  y = av;       end
      default: begin x = av;    y = msk;      end
    endcase
    sm = x + y + {32'h0, ~ci};
    case (si)
      4'h0: lg = ~av;
      4'h1: lg = ~(av | bv);
      4'h2: lg = ~av & bv;
      4'h3: lg = '0;
      4'h4: lg = ~(av & bv);
      4'h5: lg = ~bv;
      4'h6: lg = av ^ bv;
      4'h7: lg = av & ~bv;
      4'h8: lg = ~av | bv;
      4'h9: lg = ~(av ^ bv);
      4'hA: lg = bv;
      4'hB: lg = av & bv;
      4'hC: lg = '1;
      4'hD: lg = av | ~bv;
      4'hE: lg = av | bv;
      default: lg = av;
    endcase
    fo = mi ? lg[31:0] & msk[31:0] : sm[31:0] & msk[31:0];
    co = ~sm[w];
    eq = (fo == msk[31:0]);
  endfunction

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic run_op(input int w, input logic [31:0] ai, input logic [31:0] bi,
                        input logic [3:0] si, input logic mi, input logic ci,
                        output logic [31:0] fo, output logic co, output logic eo,
                        output int lat, output int bcnt);
    logic bo, dn;
    a = ai; b = bi; s = si; m = mi; c_in = ci;
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    lat  = 1;
    bcnt = 0;
    get_out(w, fo, bo, dn, eo, co);
    while (!dn && lat < 64) begin
      if (bo) bcnt++;
      @(negedge clk);
      lat++;
      get_out(w, fo, bo, dn, eo, co);
    end
    if (!dn) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout w%0d: no done after %0d cycles", w, lat);
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  s;
    logic        m, cin;
    logic [15:0] ef;
    logic        ec, eeq;
    logic        chk_c;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] fo, ef;
    logic        co, eo, ec, eeq, bo, dn;
    int          lat, bcnt;
    int          widths[4];

    vecs[0]  = '{16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{16'h1234, 16'h0001, 4'h9, 1'b0, 1'b1, 16'h1235, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{16'h5A5A, 16'h5A5A, 4'h6, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{16'h5A5B, 16'h5A5A, 4'h6, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{16'h00FF, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{16'h0000, 16'h0000, 4'hF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{16'h1000, 16'h0001, 4'h6, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{16'hC3C3, 16'hF00F, 4'hB, 1'b1, 1'b1, 16'hC003, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h1234, 16'h5678, 4'h3, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h1234, 16'h5678, 4'hC, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b1;
    st8 = 1'b0; st12 = 1'b0; st16 = 1'b0; st32 = 1'b0;
    repeat (3) @(negedge clk);
    get_out(16, fo, bo, dn, eo, co);
    chk("in_reset outputs", {fo[15:0], bo, dn, eo, co}, 20'h0);
    rst_n = 1'b1;

    widths = '{8, 12, 16, 32};
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      foreach (widths[i]) begin
        get_out(widths[i], fo, bo, dn, eo, co);
        chk($sformatf("idle w%0d cyc%0d", widths[i], cyc), {fo, 3'b000, bo, dn, eo, co}, 36'h0);
      end
    end

    for (int i = 0; i < 11; i++) begin
      run_op(16, {16'h0, vecs[i].a}, {16'h0, vecs[i].b}, vecs[i].s, vecs[i].m, vecs[i].cin,
             fo, co, eo, lat, bcnt);
      chk($sformatf("vec%0d f", i), fo, {16'h0, vecs[i].ef});
      chk($sformatf("vec%0d a_eq_b", i), {31'h0, eo}, {31'h0, vecs[i].eeq});
      if (vecs[i].chk_c) chk($sformatf("vec%0d c_out", i), {31'h0, co}, {31'h0, vecs[i].ec});
      chk($sformatf("vec%0d latency", i), lat, 5);
      chk($sformatf("vec%0d busy cycles", i), bcnt, 4);
      @(negedge clk);
      get_out(16, fo, bo, dn, eo, co);
      chk($sformatf("vec%0d done width", i), {30'h0, bo, dn}, 32'h0);
    end

    // start held high through BUSY, then still high in DONE: back-to-back.
    a = 32'h00F0; b = 32'h000F; s = 4'h9; m = 1'b0; c_in = 1'b1; st16 = 1'b1;
    @(negedge clk);
    chk("b2b busy0", {31'h0, busy16}, 32'h1);
    a = 32'hDEADBEEF; b = 32'h12345678; s = 4'h0; m = 1'b1; c_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("b2b busy%0d", k + 1), {30'h0, busy16, done16}, 32'h2);
    end
    @(negedge clk);
    chk("b2b done1", {30'h0, busy16, done16}, 32'h1);
    chk("b2b f1 ignores busy-phase inputs", {16'h0, f16}, 32'h00FF);
    a = 32'h0F0F; b = 32'h0101; s = 4'h6; m = 1'b1; c_in = 1'b1;
    @(negedge clk);
    chk("b2b no idle gap", {30'h0, busy16, done16}, 32'h2);
    chk("b2b f held", {16'h0, f16}, 32'h00FF);
    st16 = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("b2b done2", {30'h0, busy16, done16}, 32'h1);
    chk("b2b f2", {16'h0, f16}, 32'h0E0E);
    @(negedge clk);
    chk("b2b back to idle", {30'h0, busy16, done16}, 32'h0);

    // reset asserted while slice 2 is in progress
    a = 32'h1111; b = 32'h2222; s = 4'h9; m = 1'b0; c_in = 1'b1; st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset outputs", {f16, busy16, done16, eq16, co16}, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("midreset quiet%0d", k), {30'h0, busy16, done16}, 32'h0);
    end

    // randomized sweep against the whole-word reference
    foreach (widths[wi]) begin
      int w;
      w = widths[wi];
      for (int n = 0; n < ((w == 16) ? 250 : 1000); n++) begin
        logic [31:0] ra, rb;
        logic [3:0]  rs;
        logic        rm, rc;
        ra = $urandom;
        rb = (n % 8 == 0) ? ra : $urandom;
        rs = 4'($urandom_range(15, 0));
        rm = 1'($urandom_range(1, 0));
        rc = 1'($urandom_range(1, 0));
        run_op(w, ra, rb, rs, rm, rc, fo, co, eo, lat, bcnt);
        model(w, ra, rb, rs, rm, rc, ef, ec, eeq);
        chk($sformatf("w%0d op%0d f", w, n), fo, ef);
        chk($sformatf("w%0d op%0d c_out", w, n), {31'h0, co}, {31'h0, ec});
        chk($sformatf("w%0d op%0d a_eq_b", w, n), {31'h0, eo}, {31'h0, eeq});
        chk($sformatf("w%0d op%0d latency", w, n), lat, w / 4 + 1);
        if (n % 3 == 0) @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
